// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type, bit-reverse helper and standard CRC parameter sets
package crc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} crc_state_e;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [7:0]  CRC8_INIT        = 8'h00;
    localparam logic [7:0]  CRC8_XOR_OUT     = 8'h00;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_XOR  = 16'h0000;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT    = 32'hFFFFFFFF;
    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [63:0] bit_rev(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < w) r[6'(i)] = v[6'(w - 1 - i)];
        return r;
    endfunction
endpackage

// File: rtl/crc_step_comb.sv
// crc_step_comb: stateless DATA_W-bit CRC remainder update
// Ports: crc_i current remainder, data_i beat payload, crc_o remainder after all DATA_W bit-steps.
module crc_step_comb #(
    parameter int              CRC_W      = 8,
    parameter int              DATA_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = 8'h07,
    parameter bit              REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);
    if (CRC_W == 1) begin : g_w1
        always_comb begin
            logic d;
            crc_o = crc_i;
            for (int i = 0; i < DATA_W; i++) begin
                d = REFLECT_IN ? data_i[i] : data_i[DATA_W-1-i];
                crc_o = (crc_o ^ d) & POLY[0];
            end
        end
    end else begin : g_wn
        always_comb begin
            logic fb;
            crc_o = crc_i;
            for (int i = 0; i < DATA_W; i++) begin
                fb = crc_o[CRC_W-1] ^ (REFLECT_IN ? data_i[i] : data_i[DATA_W-1-i]);
                crc_o = {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
            end
        end
    end
endmodule

// File: rtl/crc_stream.sv
// crc_stream: valid/ready streaming CRC engine with a held finished-CRC output
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_last beat input;
//        out_valid/out_ready/out_crc result handshake; busy high while a frame is in progress.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               CRC_W       = 8,
    parameter int               DATA_W      = 8,
    parameter logic [CRC_W-1:0] POLY        = 8'h07,
    parameter logic [CRC_W-1:0] INIT        = '0,
    parameter logic [CRC_W-1:0] XOR_OUT     = '0,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              busy
);
    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, out_crc_q, out_crc_d, step, fin;
    logic             accept;

    // crc_q sits at INIT whenever the FSM is idle, so it doubles as the frame seed.
    crc_step_comb #(
        .CRC_W(CRC_W), .DATA_W(DATA_W), .POLY(POLY), .REFLECT_IN(REFLECT_IN)
    ) u_step (
        .crc_i(crc_q), .data_i(in_data), .crc_o(step)
    );

    assign in_ready  = state_q != DONE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == RUN;
    assign out_crc   = out_crc_q;
    assign accept    = in_valid && in_ready;
    assign fin       = (REFLECT_OUT ? CRC_W'(bit_rev(64'(step), CRC_W)) : step) ^ XOR_OUT;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        out_crc_d = out_crc_q;
        if (accept) begin
            crc_d     = step;
            state_d   = in_last ? DONE : RUN;
            out_crc_d = in_last ? fin : out_crc_q;
        end
        // Leaving DONE never overlaps an accept, which gives the one-cycle bubble.
        if (state_q == DONE && out_ready) begin
            state_d = IDLE;
            crc_d   = INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            out_crc_q <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            out_crc_q <= out_crc_d;
        end
    end
endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: scoreboard bench for CRC-8, CRC-16/CCITT-FALSE and CRC-32 configurations
module tb_crc_stream;
    import crc_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic a_in_ready, a_out_valid, a_busy;
    logic b_in_ready, b_out_valid, b_busy;
    logic c_in_ready, c_out_valid, c_busy;
    logic [7:0]  a_out_crc;
    logic [15:0] b_out_crc;
    logic [31:0] c_out_crc;
    logic d_in_valid = 1'b0, d_in_last = 1'b0, d_out_ready = 1'b0;
    logic [31:0] d_in_data = '0;
    logic d_in_ready, d_out_valid, d_busy;
    logic [31:0] d_out_crc;

    int tests = 0, fails = 0;
    logic [7:0]  qa[$];
    logic [15:0] qb[$];
    logic [31:0] qc[$], qd[$];
    logic [7:0]  str[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0]  nogap_crc;
    logic [7:0]  e8;
    logic [15:0] e16;
    logic [31:0] e32;

    always #5 clk = ~clk;

    crc_stream u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_crc(a_out_crc), .busy(a_busy)
    );

    crc_stream #(.CRC_W(16), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_CCITT_INIT), .XOR_OUT(CRC16_CCITT_XOR)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_crc(b_out_crc), .busy(b_busy)
    );

    crc_stream #(.CRC_W(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
                 .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(c_out_valid), .out_ready(out_ready), .out_crc(c_out_crc), .busy(c_busy)
    );

    crc_stream #(.CRC_W(32), .DATA_W(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
                 .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .in_last(d_in_last), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_crc(d_out_crc), .busy(d_busy)
    );

    // Textbook reflected CRC-32 (table-less, right-shifting) used as the reference.
    function automatic logic [31:0] crc32_ref(input logic [7:0] m[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (m[i]) begin
            c ^= {24'h0, m[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic put(input logic [7:0] d, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = a_in_ready;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL put_timeout in_ready got 0 want 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({a_out_valid, a_busy, b_out_valid, c_out_valid, d_out_valid} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {a_out_valid, a_busy, b_out_valid, c_out_valid, d_out_valid});
        end
        tests++;
        if ({a_out_crc, b_out_crc, c_out_crc, d_out_crc} !== 88'h0) begin
            fails++; $display("FAIL reset_crc got %h %h %h %h want all zero", a_out_crc, b_out_crc, c_out_crc, d_out_crc);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({a_in_ready, d_in_ready} !== 2'b11) begin
            fails++; $display("FAIL reset_in_ready got %b want 11", {a_in_ready, d_in_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        qa.push_back(8'hF4); qb.push_back(16'h29B1); qc.push_back(32'hCBF43926);
        for (int i = 0; i < 9; i++) begin
            put(str[i], i == 8);
            if (i < 8) begin
                tests++;
                if (a_busy !== 1'b1) begin
                    fails++; $display("FAIL busy_beat%0d got %b want 1", i + 1, a_busy);
                end
            end
        end
        tests++;
        if ({a_out_valid, a_busy, a_in_ready, b_out_valid, c_out_valid} !== 5'b10011) begin
            fails++; $display("FAIL vec_done_flags got %b want 10011", {a_out_valid, a_busy, a_in_ready, b_out_valid, c_out_valid});
        end
        e8 = qa.pop_front(); tests++;
        if (a_out_crc !== e8) begin fails++; $display("FAIL crc8_string got %h want %h", a_out_crc, e8); end
        e16 = qb.pop_front(); tests++;
        if (b_out_crc !== e16) begin fails++; $display("FAIL crc16_string got %h want %h", b_out_crc, e16); end
        e32 = qc.pop_front(); tests++;
        if (c_out_crc !== e32) begin fails++; $display("FAIL crc32_string got %h want %h", c_out_crc, e32); end
        nogap_crc = a_out_crc;
        release_out();
        tests++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            fails++; $display("FAIL vec_release got %b want 01", {a_out_valid, a_in_ready});
        end
    endtask

    task automatic test_word32();
        logic [7:0] m[$];
        for (int i = 0; i < 8; i++) m.push_back(str[i]);
        qd.push_back(crc32_ref(m));
        d_in_valid = 1'b1; d_in_data = 32'h34333231; d_in_last = 1'b0;
        @(posedge clk); #1;
        d_in_data = 32'h38373635; d_in_last = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0; d_in_last = 1'b0;
        tests++;
        if (d_out_valid !== 1'b1) begin fails++; $display("FAIL word32_valid got %b want 1", d_out_valid); end
        e32 = qd.pop_front(); tests++;
        if (d_out_crc !== e32) begin fails++; $display("FAIL word32_crc got %h want %h", d_out_crc, e32); end
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        d_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        qa.push_back(8'h00);
        put(8'h00, 1'b1);
        in_valid = 1'b1; in_data = str[0]; in_last = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests++;
            if ({a_out_valid, a_in_ready} !== 2'b10) begin
                fails++; $display("FAIL hold_flags cycle%0d got %b want 10", n, {a_out_valid, a_in_ready});
            end
            tests++;
            if (a_out_crc !== 8'h00) begin fails++; $display("FAIL hold_crc cycle%0d got %h want 00", n, a_out_crc); end
        end
        e8 = qa.pop_front(); tests++;
        if (a_out_crc !== e8) begin fails++; $display("FAIL single_beat got %h want %h", a_out_crc, e8); end
        @(posedge clk); #1;
        release_out();
        tests++;
        if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
            fails++; $display("FAIL bubble got %b want 001", {a_out_valid, a_busy, a_in_ready});
        end
        qa.push_back(8'hF4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (a_busy !== 1'b1) begin fails++; $display("FAIL held_beat_taken got %b want 1", a_busy); end
        for (int i = 1; i < 9; i++) put(str[i], i == 8);
        e8 = qa.pop_front(); tests++;
        if (a_out_crc !== e8) begin fails++; $display("FAIL after_backpressure got %h want %h", a_out_crc, e8); end
        release_out();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) put(str[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a_busy, a_out_valid, a_in_ready, a_out_crc} !== {3'b001, 8'h00}) begin
            fails++; $display("FAIL reset_mid got busy=%b valid=%b ready=%b crc=%h want 0 0 1 00", a_busy, a_out_valid, a_in_ready, a_out_crc);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back(8'hF4);
        for (int i = 0; i < 9; i++) put(str[i], i == 8);
        e8 = qa.pop_front(); tests++;
        if (a_out_crc !== e8) begin fails++; $display("FAIL after_reset got %h want %h", a_out_crc, e8); end
        release_out();
    endtask

    task automatic test_gapped();
        qa.push_back(8'hF4);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            put(str[i], i == 8);
        end
        e8 = qa.pop_front(); tests++;
        if (a_out_crc !== e8) begin fails++; $display("FAIL gapped got %h want %h", a_out_crc, e8); end
        tests++;
        if (a_out_crc !== nogap_crc) begin fails++; $display("FAIL gapped_vs_nogap got %h want %h", a_out_crc, nogap_crc); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_word32();
        test_backpressure();
        test_reset_mid();
        test_gapped();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
